// File: rtl/operand_fetch.sv
// operand_fetch: regfile read + scoreboard issue stage; accept -> out_valid in 1 cycle, outputs held while !out_ready.
// Build option OPFETCH_BYPASS_EN: a same-cycle writeback clears the hazard and forwards wb_data to the operands.
module operand_fetch #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] in_c,
    output logic [2:0]        alu_op,
    output logic [ADDR_W-1:0] out_rd,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              busy
);

    typedef struct packed {
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        logic [2:0]        op;
        logic [ADDR_W-1:0] rd;
    } issue_t;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   pend_q, pend_d, pend_eff, wb_mask, set_mask;
    issue_t            out_q, out_d;
    logic              out_vld_q;
    logic              wb_live, hazard, accept;
    logic [DATA_W-1:0] rd_b, rd_c;

    assign wb_live = wb_en && (wb_addr != '0);
    assign wb_mask = wb_live ? ({{(NREG-1){1'b0}}, 1'b1} << wb_addr) : '0;

`ifdef OPFETCH_BYPASS_EN
    // A register being written back this cycle is already safe to read.
    assign pend_eff = pend_q & ~wb_mask;
    assign rd_b     = (wb_live && wb_addr == in_rs1) ? wb_data : regs_q[in_rs1];
    assign rd_c     = (wb_live && wb_addr == in_rs2) ? wb_data : regs_q[in_rs2];
`else
    assign pend_eff = pend_q;
    assign rd_b     = regs_q[in_rs1];
    assign rd_c     = regs_q[in_rs2];
`endif

    assign hazard   = pend_eff[in_rs1] | pend_eff[in_rs2] | pend_eff[in_rd];
    assign in_ready = (!out_vld_q || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    assign set_mask = (accept && in_rd != '0) ? ({{(NREG-1){1'b0}}, 1'b1} << in_rd) : '0;

    // Set after clear: a same-edge accept to the written-back index keeps it pending.
    assign pend_d = (pend_q & ~wb_mask) | set_mask;

    always_comb begin
        out_d    = out_q;
        out_d.b  = rd_b;
        out_d.c  = rd_c;
        out_d.op = in_op;
        out_d.rd = in_rd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            pend_q    <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            if (wb_live) regs_q[wb_addr] <= wb_data;
            pend_q <= pend_d;
            if (accept) begin
                out_q     <= out_d;
                out_vld_q <= 1'b1;
            end else if (out_ready) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_vld_q;
    assign in_b      = out_q.b;
    assign in_c      = out_q.c;
    assign alu_op    = out_q.op;
    assign out_rd    = out_q.rd;
    assign busy      = |pend_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch; expectations adapt to OPFETCH_BYPASS_EN.
module tb_operand_fetch;

`ifdef OPFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk, rst_n;
    logic       in_valid, in_ready;
    logic [2:0] in_op;
    logic [2:0] in_rd, in_rs1, in_rs2;
    logic       out_valid, out_ready;
    logic [7:0] in_b, in_c;
    logic [2:0] alu_op, out_rd;
    logic       wb_en;
    logic [2:0] wb_addr;
    logic [7:0] wb_data;
    logic       busy;

    int checks = 0;
    int errors = 0;

    operand_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .out_valid(out_valid), .out_ready(out_ready),
        .in_b(in_b), .in_c(in_c), .alu_op(alu_op), .out_rd(out_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_wb(input logic [2:0] a, input logic [7:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick;
        wb_en = 1'b0;
    endtask

    task automatic drive(input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2);
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_b, in_c, alu_op, out_rd} !== 23'd0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", {out_valid, in_b, in_c, alu_op, out_rd});
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_issue;
        do_wb(3'd1, 8'h05);
        do_wb(3'd2, 8'h03);
        drive(3'b001, 3'd3, 3'd1, 3'd2);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL issue_ready got %b exp 1", in_ready); end
        tick;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_b, in_c, alu_op, out_rd} !== {1'b1, 8'h05, 8'h03, 3'b001, 3'd3}) begin
            errors++; $display("FAIL issue_out got %h exp %h", {out_valid, in_b, in_c, alu_op, out_rd},
                               {1'b1, 8'h05, 8'h03, 3'b001, 3'd3});
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL issue_busy got %b exp 1", busy); end
    endtask

    task automatic test_raw;
        drive(3'b000, 3'd5, 3'd3, 3'd0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall0 got %b exp 0", in_ready); end
        tick;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall1 got %b exp 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_drain got %b exp 0", out_valid); end
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 8'h02;
        #1;
        checks++;
        if (in_ready !== BYP) begin errors++; $display("FAIL raw_wb_cycle_ready got %b exp %b", in_ready, BYP); end
        tick;
        wb_en = 1'b0;
        if (!BYP) begin
            #1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_after_wb_ready got %b exp 1", in_ready); end
            tick;
        end
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_b, in_c, out_rd} !== {1'b1, 8'h02, 8'h00, 3'd5}) begin
            errors++; $display("FAIL raw_out got %h exp %h", {out_valid, in_b, in_c, out_rd}, {1'b1, 8'h02, 8'h00, 3'd5});
        end
        do_wb(3'd5, 8'h07);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL raw_busy_clear got %b exp 0", busy); end
    endtask

    task automatic test_backpressure;
        drive(3'b010, 3'd6, 3'd1, 3'd2);
        tick;
        out_ready = 1'b0;
        drive(3'b011, 3'd7, 3'd2, 3'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0", i, in_ready); end
            checks++;
            if ({out_valid, in_b, in_c, alu_op, out_rd} !== {1'b1, 8'h05, 8'h03, 3'b010, 3'd6}) begin
                errors++; $display("FAIL bp_hold[%0d] got %h exp %h", i, {out_valid, in_b, in_c, alu_op, out_rd},
                                   {1'b1, 8'h05, 8'h03, 3'b010, 3'd6});
            end
            tick;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
        tick;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_b, in_c, alu_op, out_rd} !== {1'b1, 8'h03, 8'h05, 3'b011, 3'd7}) begin
            errors++; $display("FAIL bp_next got %h exp %h", {out_valid, in_b, in_c, alu_op, out_rd},
                               {1'b1, 8'h03, 8'h05, 3'b011, 3'd7});
        end
        tick;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed got %b exp 0", out_valid); end
        do_wb(3'd6, 8'h00);
        do_wb(3'd7, 8'h00);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy_clear got %b exp 0", busy); end
    endtask

    task automatic test_r0;
        do_wb(3'd0, 8'hFF);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL r0_wb_busy got %b exp 0", busy); end
        drive(3'b000, 3'd0, 3'd0, 3'd1);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %b exp 1", in_ready); end
        tick;
        checks++;
        if ({out_valid, in_b, in_c, busy} !== {1'b1, 8'h00, 8'h05, 1'b0}) begin
            errors++; $display("FAIL r0_out got %h exp %h", {out_valid, in_b, in_c, busy}, {1'b1, 8'h00, 8'h05, 1'b0});
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL r0_no_stall got %b exp 1", in_ready); end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_simul;
        drive(3'b000, 3'd4, 3'd1, 3'd2);
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h09;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL sim_ready got %b exp 1", in_ready); end
        tick;
        wb_en = 1'b0;
        checks++;
        if ({busy, in_b, out_rd} !== {1'b1, 8'h05, 3'd4}) begin
            errors++; $display("FAIL sim_set_wins got %h exp %h", {busy, in_b, out_rd}, {1'b1, 8'h05, 3'd4});
        end
        drive(3'b000, 3'd5, 3'd4, 3'd0);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL sim_dep_stall got %b exp 0", in_ready); end
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL sim_ready_no_valid got %b exp 0", in_ready); end
        tick;
        do_wb(3'd4, 8'h0A);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL sim_busy_clear got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        drive(3'b001, 3'd3, 3'd1, 3'd2);
        tick;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, busy} !== 2'b11) begin errors++; $display("FAIL rm_pre got %b exp 11", {out_valid, busy}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_b, in_c, alu_op, out_rd, busy} !== 24'd0) begin
            errors++; $display("FAIL rm_async got %h exp 0", {out_valid, in_b, in_c, alu_op, out_rd, busy});
        end
        tick;
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(3'b000, 3'd3, 3'd1, 3'd2);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", in_ready); end
        tick;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, in_b, in_c} !== {1'b1, 8'h00, 8'h00}) begin
            errors++; $display("FAIL rm_regs_zero got %h exp %h", {out_valid, in_b, in_c}, {1'b1, 8'h00, 8'h00});
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        #2;
        test_reset;
        test_issue;
        test_raw;
        test_backpressure;
        test_r0;
        test_simul;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-fetch/issue stage directly upstream of the 8-bit ALU.
- Holds an 8-entry x 8-bit register file and decodes incoming instruction fields.
- Reads two source operands and presents in_b, in_c, alu_op and rd to the ALU through a valid/ready output register.
- A scoreboard stalls issue on read-after-write and write-after-write hazards. The ALU result returns through a writeback port.

Parameters:
- DATA_W, 8, operand/register width (matches ALU in_b/in_c).
- NREG, 8, number of architectural registers; r0 reads as zero and ignores writes.
- ADDR_W, 3, register index width; log2(NREG).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  stage accepts instruction this cycle.
- in_op  input  3  ALU op code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT.
- in_rd  input  ADDR_W  destination register.
- in_rs1  input  ADDR_W  source for in_b.
- in_rs2  input  ADDR_W  source for in_c.
- out_valid  output  1  operands valid to ALU.
- out_ready  input  1  ALU consumes operands.
- in_b  output  DATA_W  operand 1 (value of rs1).
- in_c  output  DATA_W  operand 2 (value of rs2).
- alu_op  output  3  registered op code.
- out_rd  output  ADDR_W  registered destination, carried to writeback.
- wb_en  input  1  writeback strobe.
- wb_addr  input  ADDR_W  writeback register.
- wb_data  input  DATA_W  writeback value (ALU result).
- busy  output  1  OR of all pending scoreboard bits.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, pending = 0, out_valid = 0, in_b/in_c/alu_op/out_rd = 0, busy = 0. Reset mid-operation discards the in-flight instruction and all pending state.
- Register file: wb_en with wb_addr != 0 writes wb_data at the clock edge. Writes to r0 are dropped and do not clear anything; r0 is never pending.
- Hazard: true if pending[rs1], pending[rs2] or pending[rd] is set. Index 0 is never pending.
- in_ready = (!out_valid || out_ready) && !hazard. It depends only on the fields and state, never on in_valid.
- Accept when in_valid && in_ready. On the next edge:
  - out_valid = 1.
  - in_b/in_c = register values, or bypassed wb_data.
  - alu_op = in_op; out_rd = in_rd.
  - pending[in_rd] is set (rd != 0).
- Output hold: out_valid && !out_ready holds all outputs stable. out_valid drops only when consumed with no new accept.
- Latency: 1 cycle from accept to out_valid; full throughput (1/cycle) when hazard-free.
- Scoreboard: wb_en clears pending[wb_addr]. If the same edge both sets (accept) and clears the same index, set wins.
- in_op values 101–111 are passed through unchanged; the ALU defines their result.

Optional Feature:
- Macro OPFETCH_BYPASS_EN.
- Defined:
  - A pending bit cleared by wb_en in the current cycle is not a hazard.
  - A source matching wb_addr (!= 0) takes wb_data at accept (write-before-read bypass).
  - Back-to-back dependent issue has 0 bubbles after writeback.
- Undefined:
  - Hazard uses the registered pending bits only.
  - The dependent instruction accepts the cycle after writeback, reading the array.
  - 1 bubble per dependency; no wb_data-to-output path.

Test Plan:
- Reset: assert rst_n=0 mid-issue with out_valid=1 -> out_valid=0, in_b=in_c=0, busy=0 immediately (asynchronous); all registers read 0 afterwards.
- Preload r1=0x05, r2=0x03 via wb; issue op=001 rd=3 rs1=1 rs2=2 -> next cycle out_valid=1, in_b=0x05, in_c=0x03, alu_op=001, out_rd=3, busy=1.
- RAW: issue rd=3, then rs1=3 with no wb -> in_ready=0 until wb_en wb_addr=3 wb_data=0x02.
  - BYPASS_EN: accepted in the wb cycle, in_b=0x02.
  - Without BYPASS_EN: accepted 1 cycle later, in_b=0x02.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0; out_ready=1 -> next instruction loads on the following edge.
- r0: wb_en wb_addr=0 wb_data=0xFF, then issue rs1=0 rd=0 -> in_b=0x00, no stall, busy unchanged.
- Simultaneous: wb_en wb_addr=4 while accepting rd=4 (no hazard with BYPASS_EN) -> pending[4]=1 afterwards; a following rs1=4 stalls.
